// File: rtl/id_ex_hazard_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_if
// Bundle of the signals between the ID stage, the ID/EX pipeline register and
// the EX stage.
//   master : ID-side producer. Drives the decoder fields, ID operands and the
//            downstream flush request. Observes stall_o and the EX-side copies.
//   slave  : the ID/EX register itself. Consumes the id_* fields and flush_i.
//            Produces stall_o, the ex_* registers and the debug counters.
// Parameters:
//   DW : datapath width (PC+4, register data, immediate)
//   CW : width of the stall / flush event counters
// ----------------------------------------------------------------------------
interface id_ex_if #(
    parameter int DW = 32,
    parameter int CW = 16
);
    // ID-side inputs to the stage
    logic          id_valid_i;
    logic          id_reg_write_i;
    logic [2:0]    id_alu_op_i;
    logic          id_alu_src_i;
    logic          id_reg_dst_i;
    logic          id_branch_i;
    logic [1:0]    id_branch_type_i;
    logic          id_mem_read_i;
    logic          id_mem_write_i;
    logic          id_mem_to_reg_i;
    logic [DW-1:0] id_pc4_i;
    logic [DW-1:0] id_rs_data_i;
    logic [DW-1:0] id_rt_data_i;
    logic [DW-1:0] id_imm_i;
    logic [4:0]    id_rs_i;
    logic [4:0]    id_rt_i;
    logic [4:0]    id_rd_i;
    logic          flush_i;

    // Stage outputs
    logic          stall_o;
    logic          ex_valid_o;
    logic          ex_illegal_o;
    logic          ex_reg_write_o;
    logic [2:0]    ex_alu_op_o;
    logic          ex_alu_src_o;
    logic          ex_reg_dst_o;
    logic          ex_branch_o;
    logic [1:0]    ex_branch_type_o;
    logic          ex_mem_read_o;
    logic          ex_mem_write_o;
    logic          ex_mem_to_reg_o;
    logic [DW-1:0] ex_pc4_o;
    logic [DW-1:0] ex_rs_data_o;
    logic [DW-1:0] ex_rt_data_o;
    logic [DW-1:0] ex_imm_o;
    logic [4:0]    ex_rs_o;
    logic [4:0]    ex_rt_o;
    logic [4:0]    ex_rd_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    modport master (
        output id_valid_i, id_reg_write_i, id_alu_op_i, id_alu_src_i,
               id_reg_dst_i, id_branch_i, id_branch_type_i, id_mem_read_i,
               id_mem_write_i, id_mem_to_reg_i, id_pc4_i, id_rs_data_i,
               id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
        input  stall_o, ex_valid_o, ex_illegal_o, ex_reg_write_o, ex_alu_op_o,
               ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_branch_type_o,
               ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_pc4_o,
               ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_reg_write_i, id_alu_op_i, id_alu_src_i,
               id_reg_dst_i, id_branch_i, id_branch_type_i, id_mem_read_i,
               id_mem_write_i, id_mem_to_reg_i, id_pc4_i, id_rs_data_i,
               id_rt_data_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
        output stall_o, ex_valid_o, ex_illegal_o, ex_reg_write_o, ex_alu_op_o,
               ex_alu_src_o, ex_reg_dst_o, ex_branch_o, ex_branch_type_o,
               ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_pc4_o,
               ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ----------------------------------------------------------------------------
// id_ex_hazard_reg
// ID/EX pipeline register of the 5-stage MIPS pipeline with load-use hazard
// detection, branch flush and saturating debug event counters.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   bus   : id_ex_if.slave -- id_* decoder fields / operands and flush_i in;
//           stall_o, ex_* registered copies, ex_valid_o, ex_illegal_o,
//           stall_cnt_o and flush_cnt_o out.
// Parameters DW / CW must match the connected interface instance.
// ----------------------------------------------------------------------------
module id_ex_hazard_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    id_ex_if.slave    bus
);

    localparam logic [2:0] ALU_OP_ILLEGAL = 3'b111;

    logic          r_ex_valid;
    logic          r_ex_illegal;
    logic          r_ex_reg_write;
    logic [2:0]    r_ex_alu_op;
    logic          r_ex_alu_src;
    logic          r_ex_reg_dst;
    logic          r_ex_branch;
    logic [1:0]    r_ex_branch_type;
    logic          r_ex_mem_read;
    logic          r_ex_mem_write;
    logic          r_ex_mem_to_reg;
    logic [DW-1:0] r_ex_pc4;
    logic [DW-1:0] r_ex_rs_data;
    logic [DW-1:0] r_ex_rt_data;
    logic [DW-1:0] r_ex_imm;
    logic [4:0]    r_ex_rs;
    logic [4:0]    r_ex_rt;
    logic [4:0]    r_ex_rd;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    logic          w_haz;
    logic          w_rt_match;

    // Counter increment that sticks at all ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    // Hazard against the load sitting in EX. rt is compared even for I-type
    // consumers; the occasional needless stall is accepted for simplicity.
    // A load to $0 never produces a value worth waiting for.
    assign w_rt_match = (r_ex_rt == bus.id_rs_i) | (r_ex_rt == bus.id_rt_i);
    assign w_haz      = bus.id_valid_i & r_ex_valid & r_ex_mem_read &
                        (r_ex_rt != 5'd0) & w_rt_match;

    // A flush squashes the ID instruction anyway, so upstream need not hold.
    assign bus.stall_o = w_haz & ~bus.flush_i;

    // ---- ID -> EX stage boundary ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_valid       <= 1'b0;
            r_ex_illegal     <= 1'b0;
            r_ex_reg_write   <= 1'b0;
            r_ex_alu_op      <= 3'd0;
            r_ex_alu_src     <= 1'b0;
            r_ex_reg_dst     <= 1'b0;
            r_ex_branch      <= 1'b0;
            r_ex_branch_type <= 2'd0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_mem_to_reg  <= 1'b0;
            r_ex_pc4         <= '0;
            r_ex_rs_data     <= '0;
            r_ex_rt_data     <= '0;
            r_ex_imm         <= '0;
            r_ex_rs          <= 5'd0;
            r_ex_rt          <= 5'd0;
            r_ex_rd          <= 5'd0;
            r_stall_cnt      <= '0;
            r_flush_cnt      <= '0;
        end else begin
            // Bubble by default: every side-effecting control is cleared,
            // data and register fields hold their old (don't-care) values.
            r_ex_valid      <= 1'b0;
            r_ex_illegal    <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_alu_op     <= 3'd0;
            r_ex_branch     <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;

            if (bus.flush_i) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else if (w_haz) begin
                // ID instruction is re-presented next cycle by the held front end.
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else if (bus.id_valid_i && bus.id_alu_op_i == ALU_OP_ILLEGAL) begin
                r_ex_illegal <= 1'b1;
            end else if (bus.id_valid_i) begin
                r_ex_valid       <= 1'b1;
                r_ex_reg_write   <= bus.id_reg_write_i;
                r_ex_alu_op      <= bus.id_alu_op_i;
                r_ex_alu_src     <= bus.id_alu_src_i;
                r_ex_reg_dst     <= bus.id_reg_dst_i;
                r_ex_branch      <= bus.id_branch_i;
                r_ex_branch_type <= bus.id_branch_type_i;
                r_ex_mem_read    <= bus.id_mem_read_i;
                r_ex_mem_write   <= bus.id_mem_write_i;
                r_ex_mem_to_reg  <= bus.id_mem_to_reg_i;
                r_ex_pc4         <= bus.id_pc4_i;
                r_ex_rs_data     <= bus.id_rs_data_i;
                r_ex_rt_data     <= bus.id_rt_data_i;
                r_ex_imm         <= bus.id_imm_i;
                r_ex_rs          <= bus.id_rs_i;
                r_ex_rt          <= bus.id_rt_i;
                r_ex_rd          <= bus.id_rd_i;
            end
        end
    end

    assign bus.ex_valid_o       = r_ex_valid;
    assign bus.ex_illegal_o     = r_ex_illegal;
    assign bus.ex_reg_write_o   = r_ex_reg_write;
    assign bus.ex_alu_op_o      = r_ex_alu_op;
    assign bus.ex_alu_src_o     = r_ex_alu_src;
    assign bus.ex_reg_dst_o     = r_ex_reg_dst;
    assign bus.ex_branch_o      = r_ex_branch;
    assign bus.ex_branch_type_o = r_ex_branch_type;
    assign bus.ex_mem_read_o    = r_ex_mem_read;
    assign bus.ex_mem_write_o   = r_ex_mem_write;
    assign bus.ex_mem_to_reg_o  = r_ex_mem_to_reg;
    assign bus.ex_pc4_o         = r_ex_pc4;
    assign bus.ex_rs_data_o     = r_ex_rs_data;
    assign bus.ex_rt_data_o     = r_ex_rt_data;
    assign bus.ex_imm_o         = r_ex_imm;
    assign bus.ex_rs_o          = r_ex_rs;
    assign bus.ex_rt_o          = r_ex_rt;
    assign bus.ex_rd_o          = r_ex_rd;
    assign bus.stall_cnt_o      = r_stall_cnt;
    assign bus.flush_cnt_o      = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_hazard_reg
// Self-checking bench for id_ex_hazard_reg: directed scenarios followed by
// randomized traffic, all compared against a reference model of the EX slot.
// ----------------------------------------------------------------------------
module tb_id_ex_hazard_reg;

    localparam int DW     = 32;
    localparam int CW     = 16;
    localparam int CNTMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    id_ex_if #(.DW(DW), .CW(CW)) bus ();

    id_ex_hazard_reg #(.DW(DW), .CW(CW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, illegal, reg_write, alu_src, reg_dst, branch;
        logic        mem_read, mem_write, mem_to_reg;
        logic [2:0]  alu_op;
        logic [1:0]  btype;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } ex_t;

    ex_t m;
    int  m_scnt;
    int  m_fcnt;
    int  tests;
    int  fails;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m = '{default: '0};
        m_scnt = 0;
        m_fcnt = 0;
    endfunction

    function automatic logic model_haz();
        return bus.id_valid_i && m.valid && m.mem_read && (m.rt != 0) &&
               (m.rt == bus.id_rs_i || m.rt == bus.id_rt_i);
    endfunction

    function automatic void model_bubble(input logic illegal);
        m.valid = 0; m.reg_write = 0; m.mem_read = 0; m.mem_write = 0;
        m.branch = 0; m.mem_to_reg = 0; m.alu_op = 0; m.illegal = illegal;
    endfunction

    // Applies the edge rules in priority order to the model.
    function automatic void model_edge();
        if (bus.flush_i) begin
            model_bubble(0);
            if (m_fcnt < CNTMAX) m_fcnt++;
        end else if (model_haz()) begin
            model_bubble(0);
            if (m_scnt < CNTMAX) m_scnt++;
        end else if (bus.id_valid_i && bus.id_alu_op_i == 3'b111) begin
            model_bubble(1);
        end else if (bus.id_valid_i) begin
            m.valid = 1; m.illegal = 0;
            m.reg_write = bus.id_reg_write_i; m.alu_op = bus.id_alu_op_i;
            m.alu_src = bus.id_alu_src_i; m.reg_dst = bus.id_reg_dst_i;
            m.branch = bus.id_branch_i; m.btype = bus.id_branch_type_i;
            m.mem_read = bus.id_mem_read_i; m.mem_write = bus.id_mem_write_i;
            m.mem_to_reg = bus.id_mem_to_reg_i;
            m.pc4 = bus.id_pc4_i; m.rs_data = bus.id_rs_data_i;
            m.rt_data = bus.id_rt_data_i; m.imm = bus.id_imm_i;
            m.rs = bus.id_rs_i; m.rt = bus.id_rt_i; m.rd = bus.id_rd_i;
        end else begin
            model_bubble(0);
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ctl"},
            160'({bus.ex_valid_o, bus.ex_illegal_o, bus.ex_reg_write_o, bus.ex_alu_src_o,
                  bus.ex_reg_dst_o, bus.ex_branch_o, bus.ex_branch_type_o, bus.ex_mem_read_o,
                  bus.ex_mem_write_o, bus.ex_mem_to_reg_o, bus.ex_alu_op_o}),
            160'({m.valid, m.illegal, m.reg_write, m.alu_src, m.reg_dst, m.branch,
                  m.btype, m.mem_read, m.mem_write, m.mem_to_reg, m.alu_op}));
        chk({tag, "_data"},
            160'({bus.ex_pc4_o, bus.ex_rs_data_o, bus.ex_rt_data_o, bus.ex_imm_o,
                  bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o}),
            160'({m.pc4, m.rs_data, m.rt_data, m.imm, m.rs, m.rt, m.rd}));
        chk({tag, "_cnt"}, 160'({bus.stall_cnt_o, bus.flush_cnt_o}),
            160'({CW'(m_scnt), CW'(m_fcnt)}));
    endtask

    // One clock: check stall before the edge, advance model, check after.
    task automatic cycle(input string tag);
        #1;
        chk({tag, "_stall"}, 160'(bus.stall_o), 160'(model_haz() && !bus.flush_i));
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.id_valid_i = 0; bus.id_reg_write_i = 0; bus.id_alu_op_i = 0;
        bus.id_alu_src_i = 0; bus.id_reg_dst_i = 0; bus.id_branch_i = 0;
        bus.id_branch_type_i = 0; bus.id_mem_read_i = 0; bus.id_mem_write_i = 0;
        bus.id_mem_to_reg_i = 0; bus.id_pc4_i = 0; bus.id_rs_data_i = 0;
        bus.id_rt_data_i = 0; bus.id_imm_i = 0; bus.id_rs_i = 0; bus.id_rt_i = 0;
        bus.id_rd_i = 0; bus.flush_i = 0;
    endtask

    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        idle_inputs();
        bus.id_valid_i = 1; bus.id_reg_write_i = 1; bus.id_alu_src_i = 1;
        bus.id_mem_read_i = 1; bus.id_mem_to_reg_i = 1; bus.id_alu_op_i = 3'd0;
        bus.id_rs_i = rs; bus.id_rt_i = rt; bus.id_imm_i = 32'h8;
        bus.id_pc4_i = 32'h100; bus.id_rs_data_i = 32'h1000;
    endtask

    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        idle_inputs();
        bus.id_valid_i = 1; bus.id_reg_write_i = 1; bus.id_reg_dst_i = 1;
        bus.id_alu_op_i = 3'd2; bus.id_rs_i = rs; bus.id_rt_i = rt; bus.id_rd_i = rd;
        bus.id_rs_data_i = 32'h11; bus.id_rt_data_i = 32'h22; bus.id_pc4_i = 32'h104;
    endtask

    task automatic drive_random();
        bus.id_valid_i       = ($urandom_range(3) != 0);
        bus.id_reg_write_i   = 1'($urandom_range(1));
        bus.id_alu_op_i      = 3'($urandom_range(7));
        bus.id_alu_src_i     = 1'($urandom_range(1));
        bus.id_reg_dst_i     = 1'($urandom_range(1));
        bus.id_branch_i      = 1'($urandom_range(1));
        bus.id_branch_type_i = 2'($urandom_range(3));
        bus.id_mem_read_i    = ($urandom_range(2) == 0);
        bus.id_mem_write_i   = 1'($urandom_range(1));
        bus.id_mem_to_reg_i  = 1'($urandom_range(1));
        bus.id_pc4_i         = $urandom();
        bus.id_rs_data_i     = $urandom();
        bus.id_rt_data_i     = $urandom();
        bus.id_imm_i         = $urandom();
        bus.id_rs_i          = 5'($urandom_range(7));
        bus.id_rt_i          = 5'($urandom_range(7));
        bus.id_rd_i          = 5'($urandom_range(31));
        bus.flush_i          = ($urandom_range(7) == 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();
        model_reset();

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_stall", 160'(bus.stall_o), 160'(0));
        rst_n = 1'b1;

        // Load then dependent use
        drive_lw(5'd1, 5'd5);
        cycle("lw5");
        drive_add(5'd5, 5'd6, 5'd7);
        #1;
        chk("lu_stall_hi", 160'(bus.stall_o), 160'(1));
        cycle("lu_bubble");
        chk("lu_bubble_valid", 160'(bus.ex_valid_o), 160'(0));
        chk("lu_stall_cnt", 160'(bus.stall_cnt_o), 160'(1));
        cycle("lu_use");
        chk("lu_use_valid", 160'(bus.ex_valid_o), 160'(1));
        chk("lu_use_stall_lo", 160'(bus.stall_o), 160'(0));

        // Load to $0 does not stall
        drive_lw(5'd2, 5'd0);
        cycle("lw0");
        drive_add(5'd0, 5'd3, 5'd4);
        #1;
        chk("lw0_stall_lo", 160'(bus.stall_o), 160'(0));
        cycle("lw0_use");
        chk("lw0_use_valid", 160'(bus.ex_valid_o), 160'(1));

        // Flush wins over a simultaneous hazard
        drive_lw(5'd1, 5'd9);
        cycle("lw9");
        drive_add(5'd9, 5'd1, 5'd2);
        bus.flush_i = 1;
        #1;
        chk("fl_stall_lo", 160'(bus.stall_o), 160'(0));
        cycle("fl_haz");
        chk("fl_cnt", 160'({bus.stall_cnt_o, bus.flush_cnt_o}), 160'({16'd1, 16'd1}));

        // Illegal opcode squashed
        drive_add(5'd1, 5'd2, 5'd3);
        bus.id_alu_op_i = 3'b111;
        cycle("illegal");
        chk("illegal_flags", 160'({bus.ex_illegal_o, bus.ex_valid_o, bus.ex_reg_write_o}),
            160'(3'b100));

        // Passthrough of an addi
        idle_inputs();
        bus.id_valid_i = 1; bus.id_alu_op_i = 3'd3; bus.id_alu_src_i = 1;
        bus.id_reg_write_i = 1; bus.id_imm_i = 32'hFFFF_FFFC; bus.id_pc4_i = 32'h0000_0010;
        bus.id_rs_i = 5'd4; bus.id_rt_i = 5'd8; bus.id_rs_data_i = 32'hCAFE_0001;
        cycle("addi");
        chk("addi_fields", 160'({bus.ex_imm_o, bus.ex_pc4_o, bus.ex_alu_op_o, bus.ex_illegal_o}),
            160'({32'hFFFF_FFFC, 32'h0000_0010, 3'd3, 1'b0}));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive_random();
            cycle("rand");
        end

        // Flush counter saturation
        idle_inputs();
        bus.flush_i = 1;
        for (int i = 0; i < 65536 + 4; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check_all("sat");
        chk("sat_flush_cnt", 160'(bus.flush_cnt_o), 160'(16'hFFFF));

        // Reset asserted mid-stall, between clock edges
        drive_lw(5'd1, 5'd6);
        cycle("lw6");
        drive_add(5'd6, 5'd6, 5'd1);
        #1;
        chk("mid_stall_hi", 160'(bus.stall_o), 160'(1));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_stall", 160'(bus.stall_o), 160'(0));
        check_all("mid_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. Sits directly downstream of the instruction decoder.
- Registers the decoder control fields and the ID-stage operands for the EX stage.
- Detects load-use hazards against the instruction currently in EX, inserts bubbles, and applies branch flushes.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- DW, 32, datapath width (PC+4, register data, sign-extended immediate)
- CW, 16, width of the stall and flush event counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_reg_write_i  in  1  decoder RegWrite
- id_alu_op_i  in  3  decoder ALU op; 3'b111 = undecodable opcode
- id_alu_src_i  in  1  decoder ALUSrc
- id_reg_dst_i  in  1  decoder RegDst
- id_branch_i  in  1  decoder Branch
- id_branch_type_i  in  2  decoder BranchType (0 beq, 1 bne, 2 bge, 3 bgt)
- id_mem_read_i  in  1  decoder MemRead
- id_mem_write_i  in  1  decoder MemWrite
- id_mem_to_reg_i  in  1  decoder MemtoReg
- id_pc4_i  in  DW  PC+4 of the ID instruction
- id_rs_data_i  in  DW  register file read port 1
- id_rt_data_i  in  DW  register file read port 2
- id_imm_i  in  DW  sign-extended immediate
- id_rs_i  in  5  rs field
- id_rt_i  in  5  rt field
- id_rd_i  in  5  rd field
- flush_i  in  1  taken branch resolved downstream; squash ID
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  EX holds a real instruction
- ex_illegal_o  out  1  EX slot is a squashed illegal opcode
- ex_*_o  out  as input  registered copies of every id_* control and data input above (same widths)
- stall_cnt_o  out  CW  load-use stall cycles, saturating
- flush_cnt_o  out  CW  flush cycles, saturating

Behaviour:
- Reset (rst_i=0, asynchronous): all ex_* outputs, ex_valid_o, ex_illegal_o, stall_cnt_o and flush_cnt_o go to 0. The EX slot is a bubble.
- Hazard (combinational from current EX registers): haz = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rt_o != 0) & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
  - id_rt_i is compared even for I-type instructions. This is conservative and intentional.
- stall_o = haz & ~flush_i. It is purely combinational, with zero latency.
- Each rising edge, first matching rule applies:
  1. flush_i=1 -> bubble. If CW bits are not all ones, flush_cnt_o increments. Flush wins over hazard because the ID instruction is wrong-path.
  2. haz=1 -> bubble. If not saturated, stall_cnt_o increments. The ID instruction is re-presented next cycle, since upstream is held by stall_o.
  3. id_valid_i=1 and id_alu_op_i=3'b111 -> bubble, with ex_illegal_o=1.
  4. id_valid_i=1 -> all ex_* capture id_* and ex_valid_o=1.
  5. otherwise -> bubble.
- Bubble definition:
  - ex_valid_o=0.
  - ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_mem_to_reg_o = 0.
  - ex_alu_op_o = 0. ex_illegal_o = 0, except under rule 3.
  - Data and register-field outputs keep their previous values; they are don't-care.
- A bubble never writes registers or memory and never branches.
- Counters saturate at all ones and never wrap.
- A stall lasts exactly one cycle per load. After the bubble, ex_mem_read_o=0, so haz clears.
- Back-to-back loads with a dependency produce one stall each.
- Reset asserted mid-stall clears state immediately. stall_o falls with ex_valid_o, with no clock required.

Test Plan:
- Load then dependent use: EX holds lw with rt=5, mem_read=1. ID presents add with rs=5, id_valid=1 -> stall_o=1. Next edge: ex_valid_o=0, all ex controls 0, stall_cnt_o=1. Following edge: add latched with ex_valid_o=1 and stall_o=0.
- Load to $0: EX holds lw with rt=0. ID uses rs=0 -> stall_o=0, and the instruction is latched normally.
- Flush with simultaneous hazard: haz conditions true and flush_i=1 -> stall_o=0. Next edge: bubble, flush_cnt_o=1, stall_cnt_o unchanged.
- Illegal opcode: id_alu_op_i=3'b111, id_reg_write_i=1 -> ex_illegal_o=1, ex_valid_o=0, ex_reg_write_o=0.
- Passthrough: addi with alu_op=3, alu_src=1, reg_write=1, imm=32'hFFFF_FFFC, pc4=32'h0000_0010 -> identical values on ex_* one edge later.
- Saturation and reset: force 65,536 flush cycles -> flush_cnt_o holds 16'hFFFF. Drop rst_i between clock edges -> all outputs 0 immediately.
